// File: rtl/rom_loader_pkg.sv
// Shared types and lane constants for the ROM download packer.
package rom_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HAVE_HI,
        ISSUE,
        FLUSH,
        DONE
    } state_t;

    localparam logic [1:0] BE_HI   = 2'b10;
    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_BOTH = 2'b11;

endpackage

// File: rtl/rom_loader_if.sv
// SDRAM write channel between the ROM loader and the ch3 mux (toggle req/ack).
interface rom_loader_if;
    logic [26:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
    logic        rw;
    logic        req;
    logic        ack;

    modport master (output addr, data, be, rw, req, input ack);
    modport slave  (input addr, data, be, rw, req, output ack);
endinterface

// File: rtl/rom_loader.sv
// Packs the HPS ioctl byte stream into big-endian 16-bit SDRAM writes with a 1-entry skid.
// Optional ROM_LOADER_CHECKSUM_EN adds a 16-bit wrapping byte sum output.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter logic [7:0]  ROM_INDEX = 8'd0,
    parameter logic [26:0] BASE_ADDR = 27'h0,
    parameter logic [26:0] MAX_SIZE  = 27'h400000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ioctl_download,
    input  logic [7:0]   ioctl_index,
    input  logic         ioctl_wr,
    input  logic [26:0]  ioctl_addr,
    input  logic [7:0]   ioctl_dout,
    output logic         ioctl_wait,
    rom_loader_if.master sdr,
    output logic         rom_ready,
    output logic         overflow
`ifdef ROM_LOADER_CHECKSUM_EN
    ,
    output logic [15:0]  checksum
`endif
);

    state_t      state, state_nxt;
    logic        req, pending;
    logic [26:0] addr_q;
    logic [15:0] data_q;
    logic [1:0]  be_q;
    logic [25:0] hold_idx;
    logic        skid_valid;
    logic [26:0] skid_addr;
    logic [7:0]  skid_data;
    logic        loading, dl_prev;
    logic        idx_hit, acc, dl_end, dl_rise;
    logic        src_skid;
    logic [26:0] src_addr;
    logic [7:0]  src_data;
    logic        do_byte, do_merge, do_flush, skid_ld, skid_clr;

    assign idx_hit  = ioctl_download && (ioctl_index == ROM_INDEX);
    assign acc      = idx_hit && ioctl_wr && (ioctl_addr < MAX_SIZE);
    assign dl_end   = loading && !ioctl_download;
    assign dl_rise  = idx_hit && !dl_prev;
    assign pending  = req != sdr.ack;

    // Once the outstanding write is acked, a parked skid byte takes priority over the bus.
    assign src_skid = (state == ISSUE) && !pending && skid_valid;
    assign src_addr = src_skid ? skid_addr : ioctl_addr;
    assign src_data = src_skid ? skid_data : ioctl_dout;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_byte   = 1'b0;
        do_merge  = 1'b0;
        do_flush  = 1'b0;
        skid_ld   = 1'b0;
        skid_clr  = 1'b0;
        case (state)
            IDLE: begin
                if (acc)         do_byte   = 1'b1;
                else if (dl_end) state_nxt = FLUSH;
            end
            HAVE_HI: begin
                if (acc) begin
                    state_nxt = ISSUE;
                    if (ioctl_addr[0] && (ioctl_addr[26:1] == hold_idx)) begin
                        do_merge = 1'b1;
                    end else begin
                        do_flush = 1'b1;
                        skid_ld  = 1'b1;
                    end
                end else if (dl_end) begin
                    do_flush  = 1'b1;
                    state_nxt = FLUSH;
                end
            end
            ISSUE: begin
                if (pending) begin
                    skid_ld = acc;
                end else if (skid_valid) begin
                    do_byte  = 1'b1;
                    skid_clr = 1'b1;
                end else if (acc) begin
                    do_byte = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            FLUSH:   if (!pending && !skid_valid) state_nxt = DONE;
            DONE:    if (dl_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (do_byte) state_nxt = src_addr[0] ? ISSUE : HAVE_HI;
    end

    always_comb begin
        ioctl_wait = pending || skid_valid;
        rom_ready  = state == DONE;
        sdr.addr   = addr_q;
        sdr.data   = data_q;
        sdr.be     = be_q;
        sdr.rw     = 1'b0;
        sdr.req    = req;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req        <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            be_q       <= '0;
            hold_idx   <= '0;
            skid_valid <= 1'b0;
            skid_addr  <= '0;
            skid_data  <= '0;
            overflow   <= 1'b0;
            loading    <= 1'b0;
            dl_prev    <= 1'b0;
        end else begin
            dl_prev <= ioctl_download;
            loading <= (state_nxt == DONE) ? 1'b0 : (loading || idx_hit);
            if (idx_hit && ioctl_wr && (ioctl_addr >= MAX_SIZE)) overflow <= 1'b1;

            if (do_byte) begin
                addr_q   <= BASE_ADDR + {src_addr[26:1], 1'b0};
                hold_idx <= src_addr[26:1];
                if (src_addr[0]) begin
                    data_q <= {8'h00, src_data};
                    be_q   <= BE_LO;
                    req    <= ~req;
                end else begin
                    // Held high byte is pre-staged as a high-lane-only write for a later flush.
                    data_q <= {src_data, 8'h00};
                    be_q   <= BE_HI;
                end
            end
            if (do_merge) begin
                data_q[7:0] <= ioctl_dout;
                be_q        <= BE_BOTH;
                req         <= ~req;
            end
            if (do_flush) req <= ~req;

            if (skid_ld) begin
                skid_valid <= 1'b1;
                skid_addr  <= ioctl_addr;
                skid_data  <= ioctl_dout;
            end else if (skid_clr) begin
                skid_valid <= 1'b0;
            end
        end
    end

`ifdef ROM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset) checksum <= '0;
        else checksum <= (dl_rise ? 16'h0 : checksum)
                       + ((acc && state != DONE) ? {8'h00, ioctl_dout} : 16'h0);
    end
`endif

    skid_overrun: assert property (@(posedge clk) disable iff (reset) !(acc && skid_valid))
        else $error("rom_loader: byte received while skid register full");

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: byte-order write model, SDRAM ack responder, literal pins.
module tb_rom_loader;
    localparam logic [7:0]  ROM_INDEX = 8'd0;
    localparam logic [26:0] BASE_ADDR = 27'h7E00000;
    localparam logic [26:0] MAX_SIZE  = 27'h400000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [26:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = 8'd0;
    logic        ioctl_wait, rom_ready, overflow;
`ifdef ROM_LOADER_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    rom_loader_if sdr_bus();

    always #5 clk = ~clk;

    rom_loader #(.ROM_INDEX(ROM_INDEX), .BASE_ADDR(BASE_ADDR), .MAX_SIZE(MAX_SIZE)) dut (
        .clk(clk), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
        .sdr(sdr_bus), .rom_ready(rom_ready), .overflow(overflow)
`ifdef ROM_LOADER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    typedef struct packed {
        logic [26:0] addr;
        logic [15:0] data;
        logic [1:0]  be;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         last_wr;
    int          checks = 0, errors = 0;
    int          ack_delay = 1, acks = 0, toggles = 0;
    bit          hi_valid = 1'b0;
    logic [26:0] hi_addr = '0;
    logic [7:0]  hi_data = 8'd0;
    bit          exp_ovf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic wr_t mk(input logic [26:0] a, input logic [15:0] d, input logic [1:0] be);
        wr_t w;
        w.addr = 27'(BASE_ADDR + (a & 27'h7FFFFFE));
        w.data = d;
        w.be   = be;
        return w;
    endfunction

    // Model: writes follow purely from byte order; an even byte pairs only with the next odd byte of its word.
    task automatic model_flush();
        if (hi_valid) exp_q.push_back(mk(hi_addr, {hi_data, 8'h00}, 2'b10));
        hi_valid = 1'b0;
    endtask

    task automatic model_byte(input logic [26:0] a, input logic [7:0] d);
        if (!(ioctl_download && ioctl_index == ROM_INDEX)) return;
        if (a >= MAX_SIZE) begin
            exp_ovf = 1'b1;
            return;
        end
        if (!a[0]) begin
            model_flush();
            hi_valid = 1'b1;
            hi_addr  = a;
            hi_data  = d;
        end else if (hi_valid && (hi_addr[26:1] == a[26:1])) begin
            exp_q.push_back(mk(a, {hi_data, d}, 2'b11));
            hi_valid = 1'b0;
        end else begin
            model_flush();
            exp_q.push_back(mk(a, {8'h00, d}, 2'b01));
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [26:0] a, input logic [7:0] d, input bit no_wait);
        int n = 0;
        while (!no_wait && ioctl_wait && n < 1000) begin
            step();
            n++;
        end
        chk("wait_bound", 32'(n < 1000), 32'd1);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        model_byte(a, d);
        step();
        ioctl_wr = 1'b0;
    endtask

    task automatic start_dl(input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        step();
    endtask

    task automatic finish_dl(input string name);
        int n = 0;
        ioctl_download = 1'b0;
        model_flush();
        while (!rom_ready && n < 500) begin
            step();
            n++;
        end
        chk({name, "_rom_ready"}, 32'(rom_ready), 32'd1);
        chk({name, "_all_writes_seen"}, 32'(exp_q.size()), 32'd0);
    endtask

    // SDRAM responder and per-cycle compare against the model queue.
    initial begin : responder
        logic seen_req;
        int   ack_cnt;
        wr_t  cur;
        seen_req = 1'b0;
        ack_cnt  = 0;
        cur      = '0;
        sdr_bus.ack = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                sdr_bus.ack = 1'b0;
                seen_req    = 1'b0;
                ack_cnt     = 0;
            end else begin
                chk("sdr_rw", 32'(sdr_bus.rw), 32'd0);
                if (sdr_bus.req !== seen_req) begin
                    seen_req = sdr_bus.req;
                    toggles++;
                    cur = {sdr_bus.addr, sdr_bus.data, sdr_bus.be};
                    last_wr = cur;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h be %b, expected none",
                                 cur.addr, cur.data, cur.be);
                    end else begin
                        wr_t e;
                        e = exp_q.pop_front();
                        chk("wr_addr", 32'(cur.addr), 32'(e.addr));
                        chk("wr_data", 32'(cur.data), 32'(e.data));
                        chk("wr_be",   32'(cur.be),   32'(e.be));
                    end
                    ack_cnt = ack_delay;
                end else if (ack_cnt > 0) begin
                    chk("hold_stable", 32'({sdr_bus.addr, sdr_bus.data, sdr_bus.be} == cur), 32'd1);
                    chk("wait_while_pending", 32'(ioctl_wait), 32'd1);
                    ack_cnt--;
                    if (ack_cnt == 0) begin
                        sdr_bus.ack = seen_req;
                        acks++;
                    end
                end
            end
        end
    end

    initial begin : main
        int t0, a0, n;
        logic r;

        repeat (3) step();
        chk("rst_wait",  32'(ioctl_wait),   32'd0);
        chk("rst_req",   32'(sdr_bus.req),  32'd0);
        chk("rst_addr",  32'(sdr_bus.addr), 32'd0);
        chk("rst_data",  32'(sdr_bus.data), 32'd0);
        chk("rst_be",    32'(sdr_bus.be),   32'd0);
        chk("rst_ready", 32'(rom_ready),    32'd0);
        chk("rst_ovf",   32'(overflow),     32'd0);
        reset = 1'b0;
        step();

        // Wrong index: nothing reaches SDRAM and the image is never reported loaded.
        start_dl(8'd1);
        send_byte(27'd0, 8'h01, 1'b0);
        send_byte(27'd1, 8'h02, 1'b0);
        send_byte(MAX_SIZE, 8'h03, 1'b0);
        ioctl_download = 1'b0;
        repeat (10) step();
        chk("idx_no_writes", 32'(toggles), 32'd0);
        chk("idx_not_ready", 32'(rom_ready), 32'd0);
        chk("idx_no_ovf",    32'(overflow),  32'd0);

        // Merged word, one toggle, one-cycle latency.
        ack_delay = 5;
        t0 = toggles;
        start_dl(ROM_INDEX);
        send_byte(27'd0, 8'h12, 1'b0);
        r = sdr_bus.req;
        send_byte(27'd1, 8'h34, 1'b0);
        chk("t1_latency", 32'(sdr_bus.req), 32'(!r));
        finish_dl("t1");
        chk("t1_toggles", 32'(toggles - t0), 32'd1);
        chk("t1_addr", 32'(last_wr.addr), 32'h7E00000);
        chk("t1_data", 32'(last_wr.data), 32'h1234);
        chk("t1_be",   32'(last_wr.be),   32'h3);

        // Odd-length image: trailing byte flushed on download end.
        ack_delay = 3;
        t0 = toggles;
        start_dl(ROM_INDEX);
        send_byte(27'd0, 8'hAA, 1'b0);
        send_byte(27'd1, 8'hBB, 1'b0);
        send_byte(27'd2, 8'hCC, 1'b0);
        finish_dl("t2");
        chk("t2_toggles", 32'(toggles - t0), 32'd2);
        chk("t2_addr", 32'(last_wr.addr), 32'h7E00002);
        chk("t2_data", 32'(last_wr.data), 32'hCC00);
        chk("t2_be",   32'(last_wr.be),   32'h2);

        // Byte arriving as ioctl_wait rises is parked and written after the first ack.
        ack_delay = 20;
        start_dl(ROM_INDEX);
        a0 = acks;
        send_byte(27'd1, 8'h11, 1'b0);
        send_byte(27'd3, 8'h22, 1'b1);
        chk("t3_wait_high", 32'(ioctl_wait), 32'd1);
        n = 0;
        while (ioctl_wait && n < 200) begin
            step();
            n++;
        end
        chk("t3_wait_bound", 32'(n < 200), 32'd1);
        chk("t3_acks_before_drop", 32'(acks - a0), 32'd2);
        send_byte(27'd4, 8'h44, 1'b0);
        send_byte(27'd5, 8'h55, 1'b0);
        finish_dl("t3");
        chk("t3_addr", 32'(last_wr.addr), 32'h7E00004);
        chk("t3_data", 32'(last_wr.data), 32'h4455);

        // Boundary: last legal word wraps past 2^27, the byte at MAX_SIZE only sets overflow.
        ack_delay = 2;
        chk("t4_ovf_clear", 32'(overflow), 32'd0);
        start_dl(ROM_INDEX);
        send_byte(MAX_SIZE - 27'd2, 8'h5A, 1'b0);
        send_byte(MAX_SIZE - 27'd1, 8'hA5, 1'b0);
        t0 = toggles;
        send_byte(MAX_SIZE, 8'h77, 1'b0);
        chk("t4_ovf_set", 32'(overflow), 32'(exp_ovf));
        finish_dl("t4");
        chk("t4_no_write", 32'(toggles - t0), 32'd0);
        chk("t4_ovf_sticky", 32'(overflow), 32'd1);
        chk("t4_addr", 32'(last_wr.addr), 32'h01FFFFE);
        chk("t4_data", 32'(last_wr.data), 32'h5AA5);

        // Reset while a write is outstanding, then a clean restart.
        ack_delay = 30;
        start_dl(ROM_INDEX);
        send_byte(27'd0, 8'h01, 1'b0);
        send_byte(27'd1, 8'h02, 1'b0);
        step();
        chk("t6_pending_wait", 32'(ioctl_wait), 32'd1);
        reset = 1'b1;
        ioctl_download = 1'b0;
        step();
        chk("t6_rst_wait",  32'(ioctl_wait),   32'd0);
        chk("t6_rst_req",   32'(sdr_bus.req),  32'd0);
        chk("t6_rst_addr",  32'(sdr_bus.addr), 32'd0);
        chk("t6_rst_data",  32'(sdr_bus.data), 32'd0);
        chk("t6_rst_be",    32'(sdr_bus.be),   32'd0);
        chk("t6_rst_ready", 32'(rom_ready),    32'd0);
        chk("t6_rst_ovf",   32'(overflow),     32'd0);
        exp_q.delete();
        hi_valid = 1'b0;
        exp_ovf  = 1'b0;
        reset = 1'b0;
        ack_delay = 2;
        step();
        start_dl(ROM_INDEX);
        send_byte(27'd4, 8'h9A, 1'b0);
        send_byte(27'd5, 8'hBC, 1'b0);
        send_byte(27'd6, 8'hDE, 1'b0);
        finish_dl("t6");
        chk("t6_addr", 32'(last_wr.addr), 32'h7E00006);
        chk("t6_data", 32'(last_wr.data), 32'hDE00);
        chk("t6_be",   32'(last_wr.be),   32'h2);
        chk("t6_ovf",  32'(overflow),     32'(exp_ovf));

        repeat (5) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
